// File: rtl/seg7_scan_if.sv
// seg7_scan_if: load handshake and board-pin bundle for seg7_scan_ctrl
interface seg7_scan_if #(parameter int NUM_DIGITS = 8);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    dec_mode;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_blank;
  logic                    busy;
  logic [6:0]              SEG;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  modport master (output load, value, dec_mode, dp_in, blink_mask, lz_blank, input busy, SEG, DP, AN);
  modport slave  (input load, value, dec_mode, dp_in, blink_mask, lz_blank, output busy, SEG, DP, AN);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with hex/decimal load, blanking, blink and overflow dash
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV_BITS  = 17,
  parameter int BLINK_DIV_BITS = 26,
  parameter bit ACTIVE_LOW     = 1
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int BW = 4*NUM_DIGITS;
  localparam int CW = 4*(NUM_DIGITS+1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [15:0][6:0] SEG_LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                          7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t r_state, w_state_nx;
  logic w_busy, w_accept;
  logic [BW-1:0] r_bin, r_disp;
  logic [CW-1:0] r_bcd, w_adj;
  logic r_carry, r_dec, r_lz, r_dlz, r_dovf;
  logic [5:0] r_cnt;
  logic [NUM_DIGITS-1:0] r_dp, r_blink, r_ddp, r_dblink;
  logic [SCAN_DIV_BITS-1:0] r_scan;
  logic [BLINK_DIV_BITS:0] r_blk;
  logic [IW-1:0] r_idx;
  logic [6:0] r_seg, w_seg_on;
  logic r_dp_o, w_dp_on, w_off, w_any;
  logic [NUM_DIGITS-1:0] r_an, w_an_on, w_keep;
  logic [3:0] w_nib;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  always_comb begin
    w_busy = r_state != IDLE;
    w_accept = r_state == IDLE && bus.load;
    w_state_nx = w_accept ? (bus.dec_mode ? CONV : COMMIT) :
                 (r_state == CONV && r_cnt == 6'(BW-1)) ? COMMIT :
                 (r_state == COMMIT) ? IDLE : r_state;
  end
  // double-dabble correction: add 3 to every BCD digit >= 5 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int j = 0; j < NUM_DIGITS+1; j++)
      w_adj[4*j +: 4] = (r_bcd[4*j +: 4] >= 4'd5) ? r_bcd[4*j +: 4] + 4'd3 : r_bcd[4*j +: 4];
  end
  always_ff @(posedge clk)
    if (rst) begin
      {r_bin, r_bcd, r_carry, r_cnt, r_dec, r_lz, r_dp, r_blink} <= '0;
      {r_disp, r_ddp, r_dblink, r_dlz, r_dovf} <= '0;
      {r_scan, r_blk, r_idx} <= '0;
      r_seg  <= ACTIVE_LOW ? 7'h7F : 7'h00;
      r_dp_o <= ACTIVE_LOW;
      r_an   <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      if (w_accept) begin
        r_bin   <= bus.value;
        r_bcd   <= '0;
        r_carry <= 1'b0;
        r_cnt   <= '0;
        r_dec   <= bus.dec_mode;
        r_lz    <= bus.lz_blank;
        r_dp    <= bus.dp_in;
        r_blink <= bus.blink_mask;
      end else if (r_state == CONV) begin
        r_bcd   <= {w_adj[CW-2:0], r_bin[BW-1]};
        r_bin   <= r_bin << 1;
        r_carry <= r_carry | w_adj[CW-1];
        r_cnt   <= r_cnt + 6'd1;
      end else if (r_state == COMMIT) begin
        r_disp   <= r_dec ? r_bcd[BW-1:0] : r_bin;
        r_dovf   <= r_dec && (r_carry || |r_bcd[CW-1:BW]);
        r_ddp    <= r_dp;
        r_dblink <= r_blink;
        r_dlz    <= r_lz;
      end
      r_scan <= r_scan + 1'b1;
      r_blk  <= r_blk + 1'b1;
      if (&r_scan) r_idx <= (r_idx == IW'(NUM_DIGITS-1)) ? '0 : r_idx + 1'b1;
      r_seg  <= ACTIVE_LOW ? ~w_seg_on : w_seg_on;
      r_dp_o <= ACTIVE_LOW ^ w_dp_on;
      r_an   <= ACTIVE_LOW ? ~w_an_on : w_an_on;
    end
  always_comb begin
    w_nib = r_disp[{r_idx, 2'b00} +: 4];
    w_any = 1'b0;
    w_keep = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      w_any = w_any | (r_disp[4*i +: 4] != 4'd0);
      w_keep[i] = w_any || i == 0;
    end
    w_off = (r_dlz && !r_dovf && !w_keep[r_idx]) || (r_blk[BLINK_DIV_BITS] && r_dblink[r_idx]);
    w_seg_on = r_dovf ? 7'h40 : ~SEG_LUT[w_nib];
    w_dp_on = r_ddp[r_idx] && !w_off && !r_dovf;
    w_an_on = w_off ? '0 : NUM_DIGITS'(1) << r_idx;
  end
  assign bus.busy = w_busy;
  assign bus.SEG  = r_seg;
  assign bus.DP   = r_dp_o;
  assign bus.AN   = r_an;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed 7-segment display controller for the Nexys4DDR board. It drives the shared-cathode bus and per-digit anodes, scanning `NUM_DIGITS` digits at a programmable rate. It accepts a value through a load handshake and shows it either as hex or as decimal, using a sequential binary-to-BCD converter. Beyond plain scanning it adds per-digit decimal points, leading-zero blanking, per-digit blinking, decimal-overflow indication and selectable output polarity; it sits between the result registers of the recognition datapath and the board pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned, 1..8; `BIN_W = 4*NUM_DIGITS`.
- `SCAN_DIV_BITS`, 17: each digit dwells 2^SCAN_DIV_BITS clocks.
- `BLINK_DIV_BITS`, 26: blink half-period is 2^BLINK_DIV_BITS clocks.
- `ACTIVE_LOW`, 1: 1 = SEG/DP/AN active-low (board); 0 = all inverted.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: capture request, one-cycle pulse.
- `value` in BIN_W: hex digits, or unsigned binary in decimal mode.
- `dec_mode` in 1: 0 = hex, 1 = decimal; captured on load.
- `dp_in` in NUM_DIGITS: decimal point per digit; captured on load.
- `blink_mask` in NUM_DIGITS: digits that blink; captured on load.
- `lz_blank` in 1: enable leading-zero blanking; captured on load.
- `busy` out 1: capture/conversion in progress; load ignored while high.
- `SEG` out 7: gfedcba segment bus, registered.
- `DP` out 1: decimal point, registered.
- `AN` out NUM_DIGITS: digit enables, one-hot, registered.

## Operation
- **Reset:**
  - scan counter, digit index and blink counter go to 0.
  - Display register and captured controls go to 0; `busy` = 0.
  - Outputs go to all-off: SEG = 7'h7F, DP = 1, AN = all 1s (ACTIVE_LOW = 1; inverted otherwise).
- **Load FSM states:** IDLE, CONV, COMMIT.
  - IDLE: `load` with `busy` = 0 latches `value` and the controls. `dec_mode` = 0 goes to COMMIT; `dec_mode` = 1 goes to CONV.
  - CONV: double-dabble, one shift per cycle for exactly BIN_W cycles, then COMMIT. BCD working width is 4*(NUM_DIGITS+1), so the overflow digits are retained.
  - COMMIT: the display register (NUM_DIGITS nibbles, dp, blink, lz, overflow flag) is written atomically in one cycle, then back to IDLE.
  - `busy` is high in CONV and COMMIT.
  - The old value stays displayed until COMMIT.
- **Overflow:** in decimal mode, `value` >= 10^NUM_DIGITS (any nonzero BCD digit above NUM_DIGITS-1) sets the overflow flag.
  - With overflow set, every digit shows '-' (g only), DP is off, and LZ blanking is not applied.
- **Scan:**
  - Counter increments every clock. When it is all-ones, the index advances.
  - The index wraps from NUM_DIGITS-1 to 0.
  - AN asserts only bit[index].
- **Decode:** hex 0–F use the standard gfedcba active-low table (0 = 7'b1000000, 1 = 7'b1111001, A = 7'b0001000, F = 7'b0001110).
- **LZ blanking:** when enabled, digits above the highest nonzero digit have AN deasserted. Digit 0 is never blanked, so value 0 shows "0".
- **Blink:** when blink counter MSB = 1, digits with `blink_mask` set have AN deasserted. The counter free-runs from reset.
- **DP:** asserted when dp bit[index] is set and the digit is not blanked.

## Timing
- Outputs are registered: SEG/DP/AN reflect the index and display register of the previous cycle (1-cycle latency).
- **Hex load:** accepted at edge t; COMMIT during t..t+1; new value on the outputs by edge t+2. `busy` is high for 1 cycle.
- **Decimal load:** `busy` is high for BIN_W+1 cycles after the accepting edge. The display register updates on the last busy edge, and outputs follow one edge later.
- `load` while `busy` = 1 is dropped, not queued.
- `rst` together with `load` or mid-conversion: `rst` wins. Conversion is aborted, the display is cleared, and `busy` = 0 on the next cycle.
- **Index wrap:** with NUM_DIGITS = 1 the index stays 0. Scan and blink counters wrap silently.
- Changes on `value`/control inputs outside of `load` have no effect.

## Test plan
- Reset, with SCAN_DIV_BITS = 2 and NUM_DIGITS = 4: after `rst`, AN = 4'b1111, SEG = 7'h7F, DP = 1, `busy` = 0. Then AN cycles 1110→1101→1011→0111, changing every 4 clocks.
- Hex load 16'hA5F0 with lz = 0, then capture a full scan: per-digit SEG = 1000000, 0001110, 0010010, 0001000. `busy` is high exactly 1 cycle.
- Decimal load 16'd1234 (BIN_W = 16): `busy` high for 17 cycles, then digits 4, 3, 2, 1. A load pulse issued mid-busy is ignored and the value is unchanged.
- Decimal load 16'd10000 (exceeds 9999): all four digits show SEG = 0111111 and DP = 1. Then decimal load 0 with lz = 1: only digit 0 is enabled, showing 1000000.
- Blink: BLINK_DIV_BITS = 4, blink_mask = 4'b0010, dp_in = 4'b0001. Digit 1's AN is never asserted while the blink MSB = 1; digit 0 asserts DP; other digits are unaffected.
- `rst` asserted mid-conversion: `busy` = 0 and outputs all-off next cycle. A following hex load of 16'h0001 displays correctly. Repeat the blink and reset scenarios with ACTIVE_LOW = 0 and check for fully inverted levels.
